// File: rtl/core_intf_trace_rom_if.sv
// Bus between a trace-replay engine (master) and the trace ROM (slave).
// oob_o exists only when TRACE_ROM_OOB_CHECK_EN is defined.
interface core_intf_trace_rom_if #(
  parameter int unsigned width_p      = 32'd74,
  parameter int unsigned addr_width_p = 32'd15
);
  logic [addr_width_p-1:0] addr_i;
  logic [width_p-1:0]      data_o;
  logic [addr_width_p-1:0] addr_max_o;
  logic                    done_seen_o;
`ifdef TRACE_ROM_OOB_CHECK_EN
  logic                    oob_o;

  modport master (output addr_i, input data_o, input addr_max_o, input done_seen_o, input oob_o);
  modport slave  (input addr_i, output data_o, output addr_max_o, output done_seen_o, output oob_o);
`else
  modport master (output addr_i, input data_o, input addr_max_o, input done_seen_o);
  modport slave  (input addr_i, output data_o, output addr_max_o, output done_seen_o);
`endif
endinterface

// File: rtl/core_intf_trace_rom.sv
// Per-core trace ROM feeding a replay engine, with a clocked monitor of progress.
// Optional macro TRACE_ROM_OOB_CHECK_EN adds a sticky out-of-range flag (oob_o).
module core_intf_trace_rom #(
  parameter int unsigned width_p      = 32'd74,
  parameter int unsigned addr_width_p = 32'd15,
  parameter int unsigned rom_id_p     = 32'd0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  core_intf_trace_rom_if.slave bus
);

  localparam logic [3:0] op_send_lp   = 4'h1;
  localparam logic [3:0] op_recv_lp   = 4'h2;
  localparam logic [3:0] op_done_lp   = 4'h3;
  localparam logic [3:0] op_dec_lp    = 4'h5;
  localparam logic [3:0] op_init_lp   = 4'h6;
  localparam logic [3:0] mem_load_lp  = 4'h0;
  localparam logic [3:0] mem_store_lp = 4'h1;

  function automatic logic [73:0] send_f(input logic [3:0] mem_op, input logic [31:0] byte_addr,
                                         input logic [31:0] wdata);
    send_f = {op_send_lp, 2'b00, mem_op, byte_addr, wdata};
  endfunction

  function automatic logic [73:0] recv_f(input logic [31:0] rdata);
    recv_f = {op_recv_lp, 38'h0, rdata};
  endfunction

  function automatic logic [73:0] ctrl_f(input logic [3:0] op, input logic [15:0] count);
    ctrl_f = {op, 54'h0, count};
  endfunction

  logic [31:0]             addr_ext_s;
  logic [width_p-1:0]      entry_s;
  logic [addr_width_p-1:0] addr_max_d, addr_max_q;
  logic                    done_seen_d, done_seen_q;

  assign addr_ext_s = 32'(bus.addr_i);

  // Trace contents; anything not listed parks the engine in done.
  always_comb begin
    entry_s = ctrl_f(op_done_lp, 16'h0);
    case (rom_id_p)
      32'd0: begin
        case (addr_ext_s)
          32'd0:   entry_s = send_f(mem_store_lp, 32'h0000_0100, 32'hDEAD_BEEF);
          32'd1:   entry_s = send_f(mem_load_lp,  32'h0000_0100, 32'h0000_0000);
          32'd2:   entry_s = recv_f(32'hDEAD_BEEF);
          default: entry_s = ctrl_f(op_done_lp, 16'h0);
        endcase
      end
      32'd1: begin
        case (addr_ext_s)
          32'd0:   entry_s = send_f(mem_store_lp, 32'h0000_0200, 32'h1234_5678);
          32'd1:   entry_s = send_f(mem_load_lp,  32'h0000_0200, 32'h0000_0000);
          32'd2:   entry_s = recv_f(32'h1234_5678);
          default: entry_s = ctrl_f(op_done_lp, 16'h0);
        endcase
      end
      32'd2: begin
        case (addr_ext_s)
          32'd0:   entry_s = ctrl_f(op_init_lp, 16'd16);
          32'd1:   entry_s = ctrl_f(op_dec_lp, 16'h0);
          32'd2:   entry_s = send_f(mem_store_lp, 32'h0000_0300, 32'hA5A5_A5A5);
          32'd3:   entry_s = send_f(mem_load_lp,  32'h0000_0300, 32'h0000_0000);
          32'd4:   entry_s = recv_f(32'hA5A5_A5A5);
          default: entry_s = ctrl_f(op_done_lp, 16'h0);
        endcase
      end
      default: entry_s = ctrl_f(op_done_lp, 16'h0);
    endcase
  end

  assign bus.data_o = entry_s;

  // Next-state for the progress monitor; address and done update independently.
  always_comb begin
    addr_max_d  = addr_max_q;
    done_seen_d = done_seen_q;
    if (bus.addr_i > addr_max_q) begin
      addr_max_d = bus.addr_i;
    end else begin
      addr_max_d = addr_max_q;
    end
    if (entry_s[73:70] == op_done_lp) begin
      done_seen_d = 1'b1;
    end else begin
      done_seen_d = done_seen_q;
    end
  end

  // Progress monitor registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_max_q  <= {addr_width_p{1'b0}};
      done_seen_q <= 1'b0;
    end else begin
      addr_max_q  <= addr_max_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign bus.addr_max_o  = addr_max_q;
  assign bus.done_seen_o = done_seen_q;

`ifdef TRACE_ROM_OOB_CHECK_EN
  // Unknown traces have no listed entries, so any address beyond 0 is out of range.
  localparam logic [31:0] last_idx_lp = (rom_id_p == 32'd2) ? 32'd5 :
                                        (rom_id_p <= 32'd1) ? 32'd3 : 32'd0;

  logic oob_d, oob_q;

  // Sticky flag for a fetch beyond the end of the selected trace.
  always_comb begin
    oob_d = oob_q;
    if (addr_ext_s > last_idx_lp) begin
      oob_d = 1'b1;
    end else begin
      oob_d = oob_q;
    end
  end

  // Out-of-range flag register; reports the first occurrence after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      oob_q <= 1'b0;
    end else begin
      if (oob_d && !oob_q) begin
        $error("core_intf_trace_rom: address %0d beyond trace end %0d", addr_ext_s, last_idx_lp);
      end
      oob_q <= oob_d;
    end
  end

  assign bus.oob_o = oob_q;
`endif

endmodule

// File: tb/tb_core_intf_trace_rom.sv
// Scoreboard bench for core_intf_trace_rom: stimulus pushes expectations, a negedge monitor checks.
module tb_core_intf_trace_rom;
  localparam int W  = 74;
  localparam int AW = 15;

  localparam logic [W-1:0] DONE = {4'h3, 70'h0};
  localparam logic [W-1:0] R0_0 = {4'h1, 70'h1_00000100_DEADBEEF};
  localparam logic [W-1:0] R0_1 = {4'h1, 70'h0_00000100_00000000};
  localparam logic [W-1:0] R0_2 = {4'h2, 70'h0_00000000_DEADBEEF};
  localparam logic [W-1:0] R1_0 = {4'h1, 70'h1_00000200_12345678};
  localparam logic [W-1:0] R1_1 = {4'h1, 70'h0_00000200_00000000};
  localparam logic [W-1:0] R1_2 = {4'h2, 70'h0_00000000_12345678};
  localparam logic [W-1:0] R2_0 = {4'h6, 70'd16};
  localparam logic [W-1:0] R2_1 = {4'h5, 70'h0};
  localparam logic [W-1:0] R2_2 = {4'h1, 70'h1_00000300_A5A5A5A5};
  localparam logic [W-1:0] R2_3 = {4'h1, 70'h0_00000300_00000000};
  localparam logic [W-1:0] R2_4 = {4'h2, 70'h0_00000000_A5A5A5A5};

  typedef struct {
    string          name;
    int             inst;
    logic [W-1:0]   data;
    logic           chk_regs;
    logic [AW-1:0]  amax;
    logic           done;
    logic           chk_oob;
    logic           oob;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  core_intf_trace_rom_if #(.width_p(W), .addr_width_p(AW)) if0 ();
  core_intf_trace_rom_if #(.width_p(W), .addr_width_p(AW)) if1 ();
  core_intf_trace_rom_if #(.width_p(W), .addr_width_p(AW)) if2 ();
  core_intf_trace_rom_if #(.width_p(W), .addr_width_p(AW)) if5 ();

  core_intf_trace_rom #(.width_p(W), .addr_width_p(AW), .rom_id_p(0)) u_rom0 (
    .clk_i(clk), .reset_i(reset_i), .bus(if0.slave));
  core_intf_trace_rom #(.width_p(W), .addr_width_p(AW), .rom_id_p(1)) u_rom1 (
    .clk_i(clk), .reset_i(reset_i), .bus(if1.slave));
  core_intf_trace_rom #(.width_p(W), .addr_width_p(AW), .rom_id_p(2)) u_rom2 (
    .clk_i(clk), .reset_i(reset_i), .bus(if2.slave));
  core_intf_trace_rom #(.width_p(W), .addr_width_p(AW), .rom_id_p(5)) u_rom5 (
    .clk_i(clk), .reset_i(reset_i), .bus(if5.slave));

  task automatic chk(input string nm, input string what, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s.%s: got %h, expected %h", nm, what, got, want);
    end
  endtask

  task automatic set_addr(input int inst, input logic [AW-1:0] a);
    case (inst)
      0: if0.addr_i = a;
      1: if1.addr_i = a;
      2: if2.addr_i = a;
      5: if5.addr_i = a;
      default: ;
    endcase
  endtask

  // Drive an address and push the expected response.
  task automatic vec(input string nm, input int inst, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input logic cr, input logic [AW-1:0] amax,
                     input logic done, input logic co, input logic oob);
    exp_t e;
    set_addr(inst, a);
    e.name = nm; e.inst = inst; e.data = d; e.chk_regs = cr; e.amax = amax;
    e.done = done; e.chk_oob = co; e.oob = oob;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [W-1:0]  d;
    logic [AW-1:0] m;
    logic          s;
    logic          o;
    while (q.size() != 0) begin
      e = q.pop_front();
      o = 1'b0;
      case (e.inst)
        0: begin d = if0.data_o; m = if0.addr_max_o; s = if0.done_seen_o; end
        1: begin
          d = if1.data_o; m = if1.addr_max_o; s = if1.done_seen_o;
`ifdef TRACE_ROM_OOB_CHECK_EN
          o = if1.oob_o;
`endif
        end
        2: begin d = if2.data_o; m = if2.addr_max_o; s = if2.done_seen_o; end
        5: begin d = if5.data_o; m = if5.addr_max_o; s = if5.done_seen_o; end
        default: begin d = {W{1'bx}}; m = {AW{1'bx}}; s = 1'bx; end
      endcase
      chk(e.name, "data", d, e.data);
      if (e.chk_regs) begin
        chk(e.name, "addr_max", W'(m), W'(e.amax));
        chk(e.name, "done_seen", W'(s), W'(e.done));
      end
`ifdef TRACE_ROM_OOB_CHECK_EN
      if (e.chk_oob) chk(e.name, "oob", W'(o), W'(e.oob));
`endif
    end
  end

  initial begin
    if0.addr_i = 15'd0; if1.addr_i = 15'd0; if2.addr_i = 15'd0; if5.addr_i = 15'd0;
    repeat (2) @(posedge clk);

    // ROM contents while reset is held; monitor registers must stay clear.
    tick();
    vec("r0_a0", 0, 15'd0, R0_0, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r1_a0", 1, 15'd0, R1_0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r2_a0", 2, 15'd0, R2_0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r5_a0", 5, 15'd0, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r0_a1", 0, 15'd1, R0_1, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r1_a1", 1, 15'd1, R1_1, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r2_a1", 2, 15'd1, R2_1, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r5_amax", 5, 15'h7FFF, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r0_a2", 0, 15'd2, R0_2, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r1_a2", 1, 15'd2, R1_2, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r2_a2", 2, 15'd2, R2_2, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r0_a3", 0, 15'd3, DONE, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r1_a3", 1, 15'd3, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r2_a3", 2, 15'd3, R2_3, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r0_a4", 0, 15'd4, DONE, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r1_a4", 1, 15'd4, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r2_a4", 2, 15'd4, R2_4, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r0_amax", 0, 15'h7FFF, DONE, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    vec("r2_a5", 2, 15'd5, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r2_a6", 2, 15'd6, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("r2_a100", 2, 15'd100, DONE, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);

    // Release reset and walk rom 0 through 0,1,3,2.
    tick();
    reset_i = 1'b0;
    set_addr(1, 15'd0); set_addr(2, 15'd0); set_addr(5, 15'd0);
    vec("seq0", 0, 15'd0, R0_0, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("seq1", 0, 15'd1, R0_1, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("seq3", 0, 15'd3, DONE, 1'b1, 15'd1, 1'b0, 1'b0, 1'b0);
    tick();
    vec("seq2", 0, 15'd2, R0_2, 1'b1, 15'd3, 1'b1, 1'b0, 1'b0);
    tick();
    vec("seq2b", 0, 15'd2, R0_2, 1'b1, 15'd3, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges clears registers, ROM output holds.
    @(posedge clk);
    #3;
    reset_i = 1'b1;
    vec("async_rst", 0, 15'd2, R0_2, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);

    // Out-of-range fetch on rom 1, and max-address saturation on the all-done ROM.
    tick();
    reset_i = 1'b0;
    vec("oob_a4", 1, 15'd4, DONE, 1'b0, 15'd0, 1'b0, 1'b1, 1'b0);
    vec("sat0", 5, 15'h7FFF, DONE, 1'b1, 15'd0, 1'b0, 1'b0, 1'b0);
    tick();
    vec("oob_a0", 1, 15'd0, R1_0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b1);
    vec("sat1", 5, 15'h7FFF, DONE, 1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b0);
    tick();
    vec("oob_hold", 1, 15'd0, R1_0, 1'b0, 15'd0, 1'b0, 1'b1, 1'b1);
    vec("sat_hold", 5, 15'd0, DONE, 1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
